// File: rtl/bank_cmd_ctrl_pkg.sv
// rtl/bank_cmd_ctrl_pkg.sv - command/state encodings and burst column helper for bank_cmd_ctrl
package bank_ctrl_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTIVATING,
    ST_ACTIVE,
    ST_WRITING,
    ST_READING,
    ST_PRECHARGING
  } state_e;

  // Beat offset wraps inside the BL-aligned block; upper column bits never change.
  function automatic logic [31:0] burst_col(input logic [31:0] base, input logic [31:0] beat,
                                            input int unsigned bl);
    logic [31:0] mask;
    mask = 32'(bl) - 32'd1;
    return (base & ~mask) | ((base + beat) & mask);
  endfunction

endpackage

// File: rtl/bank_cmd_ctrl_if.sv
// rtl/bank_cmd_ctrl_if.sv - host-side command, write and read streams of bank_cmd_ctrl
interface bank_cmd_ctrl_if #(
  parameter int DEVICE_WIDTH = 4,
  parameter int COLWIDTH     = 10,
  parameter int CHWIDTH      = 5
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [2:0]              cmd;
  logic [CHWIDTH-1:0]      cmd_row;
  logic [COLWIDTH-1:0]     cmd_col;
  logic [DEVICE_WIDTH-1:0] wdata;
  logic                    wdata_req;
  logic [DEVICE_WIDTH-1:0] rdata;
  logic                    rdata_valid;
  logic                    row_open;
  logic [CHWIDTH-1:0]      open_row;
  logic                    cmd_err;

  modport master (
    output cmd_valid, cmd, cmd_row, cmd_col, wdata,
    input  cmd_ready, wdata_req, rdata, rdata_valid, row_open, open_row, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd, cmd_row, cmd_col, wdata,
    output cmd_ready, wdata_req, rdata, rdata_valid, row_open, open_row, cmd_err
  );
endinterface

// File: rtl/bank_burst_gen.sv
// rtl/bank_burst_gen.sv - beat counter and wrapped column generator shared by read and write bursts
module bank_burst_gen
  import bank_ctrl_pkg::*;
#(
  parameter int COLWIDTH = 10,
  parameter int BL       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [COLWIDTH-1:0] start_col,
  output logic                busy,
  output logic                done,
  output logic [COLWIDTH-1:0] column
);
  localparam int BW = (BL > 1) ? $clog2(BL) : 1;

  logic                busy_q;
  logic [BW-1:0]       beat_q;
  logic [COLWIDTH-1:0] base_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      beat_q <= '0;
      base_q <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      beat_q <= '0;
      base_q <= start_col;
    end else if (busy_q) begin
      if (done) begin
        busy_q <= 1'b0;
        beat_q <= '0;
      end else begin
        beat_q <= beat_q + BW'(1);
      end
    end
  end

  assign busy   = busy_q;
  assign done   = busy_q && (beat_q == BW'(BL - 1));
  assign column = busy_q ? COLWIDTH'(burst_col(32'(base_q), 32'(beat_q), BL)) : '0;

endmodule

// File: rtl/bank_cmd_ctrl.sv
// rtl/bank_cmd_ctrl.sv - per-bank ACT/RD/WR/PRE sequencer with tRCD/tRAS/tRP and BL-beat bursts
module bank_cmd_ctrl
  import bank_ctrl_pkg::*;
#(
  parameter int DEVICE_WIDTH = 4,
  parameter int COLWIDTH     = 10,
  parameter int CHWIDTH      = 5,
  parameter int BL           = 8,
  parameter int T_RCD        = 3,
  parameter int T_RAS        = 6,
  parameter int T_RP         = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bank_cmd_ctrl_if.slave          host,
  output logic                    bank_rd_o_wr,
  output logic [CHWIDTH-1:0]      bank_row,
  output logic [COLWIDTH-1:0]     bank_column,
  output logic [DEVICE_WIDTH-1:0] bank_dqin,
  input  logic [DEVICE_WIDTH-1:0] bank_dqout
);
  localparam int TW = $clog2(T_RCD + T_RAS + T_RP) + 1;

  state_e             state_q, state_d;
  logic [TW-1:0]      trcd_q, tras_q, trp_q;
  logic [CHWIDTH-1:0] row_q;
  logic               cmd_err_q, err_d;
  logic               rd_pipe_q;
  logic               accept, load_act, load_pre, burst_start, burst_busy, burst_done;
  logic               writing;

  assign host.cmd_ready = rst_n && (state_q == ST_IDLE || state_q == ST_ACTIVE);
  assign accept         = host.cmd_valid && host.cmd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      trcd_q    <= '0;
      tras_q    <= '0;
      trp_q     <= '0;
      row_q     <= '0;
      cmd_err_q <= 1'b0;
      rd_pipe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_err_q <= err_d;
      rd_pipe_q <= (state_q == ST_READING);
      // Timers hold "cycles still to wait" and saturate at zero.
      if (load_act) begin
        trcd_q <= TW'(T_RCD - 1);
        tras_q <= TW'(T_RAS - 1);
        row_q  <= host.cmd_row;
      end else begin
        trcd_q <= (trcd_q != '0) ? trcd_q - TW'(1) : '0;
        tras_q <= (tras_q != '0) ? tras_q - TW'(1) : '0;
      end
      if (load_pre) trp_q <= TW'(T_RP - 1);
      else          trp_q <= (trp_q != '0) ? trp_q - TW'(1) : '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    err_d       = 1'b0;
    load_act    = 1'b0;
    load_pre    = 1'b0;
    burst_start = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) begin
        case (host.cmd)
          CMD_NOP: ;
          CMD_ACT: begin
            load_act = 1'b1;
            state_d  = (T_RCD == 1) ? ST_ACTIVE : ST_ACTIVATING;
          end
          default: err_d = 1'b1;
        endcase
      end
      ST_ACTIVATING: if (trcd_q <= TW'(1)) state_d = ST_ACTIVE;
      ST_ACTIVE: if (accept) begin
        case (host.cmd)
          CMD_NOP: ;
          CMD_RD: begin
            burst_start = 1'b1;
            state_d     = ST_READING;
          end
          CMD_WR: begin
            burst_start = 1'b1;
            state_d     = ST_WRITING;
          end
          CMD_PRE: begin
            if (tras_q == '0) begin
              load_pre = 1'b1;
              state_d  = (T_RP == 1) ? ST_IDLE : ST_PRECHARGING;
            end else begin
              err_d = 1'b1;
            end
          end
          default: err_d = 1'b1;
        endcase
      end
      ST_WRITING, ST_READING: if (burst_done) state_d = ST_ACTIVE;
      ST_PRECHARGING: if (trp_q <= TW'(1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  bank_burst_gen #(
    .COLWIDTH (COLWIDTH),
    .BL       (BL)
  ) u_burst (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (burst_start),
    .start_col (host.cmd_col),
    .busy      (burst_busy),
    .done      (burst_done),
    .column    (bank_column)
  );

  // Write strobes are gated by rst_n so a reset cycle never reaches the Bank.
  assign writing          = (state_q == ST_WRITING) && burst_busy;
  assign bank_rd_o_wr     = writing && rst_n;
  assign host.wdata_req   = writing && rst_n;
  assign bank_dqin        = writing ? host.wdata : '0;
  assign bank_row         = row_q;
  assign host.row_open    = (state_q == ST_ACTIVATING) || (state_q == ST_ACTIVE) ||
                            (state_q == ST_WRITING)    || (state_q == ST_READING);
  assign host.open_row    = host.row_open ? row_q : '0;
  assign host.cmd_err     = cmd_err_q;
  assign host.rdata_valid = rd_pipe_q;
  assign host.rdata       = rd_pipe_q ? bank_dqout : '0;

endmodule

// File: tb/tb_bank_cmd_ctrl.sv
// tb/tb_bank_cmd_ctrl.sv - randomized self-checking bench for bank_cmd_ctrl against a timestamp model
module tb_bank_cmd_ctrl;
  localparam int DW = 4, CW = 10, RW = 5, BL = 8;
  localparam int T_RCD = 3, T_RAS = 6, T_RP = 2;
  localparam int MEMSZ = 1 << (RW + CW);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bank_cmd_ctrl_if #(.DEVICE_WIDTH(DW), .COLWIDTH(CW), .CHWIDTH(RW)) host ();

  logic          bank_rd_o_wr;
  logic [RW-1:0] bank_row;
  logic [CW-1:0] bank_column;
  logic [DW-1:0] bank_dqin;
  logic [DW-1:0] bank_dqout = '0;

  bank_cmd_ctrl #(
    .DEVICE_WIDTH(DW), .COLWIDTH(CW), .CHWIDTH(RW), .BL(BL),
    .T_RCD(T_RCD), .T_RAS(T_RAS), .T_RP(T_RP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host         (host),
    .bank_rd_o_wr (bank_rd_o_wr),
    .bank_row     (bank_row),
    .bank_column  (bank_column),
    .bank_dqin    (bank_dqin),
    .bank_dqout   (bank_dqout)
  );

  // Bank: write on rd_o_wr, registered read of the addressed cell every cycle.
  logic [DW-1:0] bank_mem [MEMSZ] = '{default: '0};
  always @(posedge clk) begin
    if (bank_rd_o_wr) bank_mem[{bank_row, bank_column}] <= bank_dqin;
    bank_dqout <= bank_mem[{bank_row, bank_column}];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: event timestamps (edge numbers) rather than states.
  typedef struct { int at; logic [DW-1:0] d; } rd_t;
  int            cyc;
  bit            m_open;
  int            act_e, pre_e, burst_a;
  bit            burst_wr;
  logic [RW-1:0] m_row, m_bank_row;
  int            m_base;
  bit            m_err;
  rd_t           rd_q[$];
  logic [DW-1:0] ref_mem [MEMSZ] = '{default: '0};

  function automatic int col_of(input int base, input int k);
    return (base / BL) * BL + ((base % BL) + k) % BL;
  endfunction

  function automatic bit m_ready();
    if (!m_open) return cyc >= pre_e + T_RP;
    return (cyc >= act_e + T_RCD) && (cyc > burst_a + BL);
  endfunction

  task automatic m_reset();
    m_open = 0; act_e = -1000; pre_e = -1000; burst_a = -1000;
    burst_wr = 0; m_row = '0; m_bank_row = '0; m_base = 0; m_err = 0;
    rd_q.delete();
  endtask

  task automatic step(input bit rst, input bit v, input logic [2:0] c, input logic [RW-1:0] r,
                      input logic [CW-1:0] col, input logic [DW-1:0] wd);
    bit            exp_rv, rdy, inb;
    logic [DW-1:0] exp_rd;
    int            k;
    @(negedge clk);
    exp_rv = 0;
    exp_rd = '0;
    if (rd_q.size() > 0 && rd_q[0].at == cyc) begin
      exp_rv = 1;
      exp_rd = rd_q[0].d;
      rd_q.delete(0);
    end
    check_eq("rdata_valid", 32'(host.rdata_valid), 32'(exp_rv));
    check_eq("rdata", 32'(host.rdata), 32'(exp_rd));
    check_eq("cmd_err", 32'(host.cmd_err), 32'(m_err));
    check_eq("row_open", 32'(host.row_open), 32'(m_open));
    check_eq("open_row", 32'(host.open_row), m_open ? 32'(m_row) : 32'd0);
    check_eq("bank_row", 32'(bank_row), 32'(m_bank_row));
    rst_n = rst; host.cmd_valid = v; host.cmd = c; host.cmd_row = r; host.cmd_col = col;
    host.wdata = wd;
    #1;
    rdy = rst && m_ready();
    k   = cyc - burst_a - 1;
    inb = (k >= 0) && (k < BL);
    check_eq("cmd_ready", 32'(host.cmd_ready), 32'(rdy));
    check_eq("wdata_req", 32'(host.wdata_req), 32'(rst && inb && burst_wr));
    check_eq("bank_rd_o_wr", 32'(bank_rd_o_wr), 32'(rst && inb && burst_wr));
    check_eq("bank_column", 32'(bank_column), inb ? 32'(col_of(m_base, k)) : 32'd0);
    check_eq("bank_dqin", 32'(bank_dqin), (inb && burst_wr) ? 32'(wd) : 32'd0);
    @(posedge clk);
    m_err = 0;
    if (!rst) begin
      m_reset();
    end else begin
      if (inb && burst_wr) ref_mem[{m_row, CW'(col_of(m_base, k))}] = wd;
      if (v && rdy) begin
        if (!m_open) begin
          if (c == 3'd1) begin
            m_open = 1; act_e = cyc; m_row = r; m_bank_row = r;
          end else if (c != 3'd0) begin
            m_err = 1;
          end
        end else begin
          case (c)
            3'd0: ;
            3'd2, 3'd3: begin
              burst_a = cyc; burst_wr = (c == 3'd3); m_base = int'(col);
              if (c == 3'd2)
                for (int j = 0; j < BL; j++)
                  rd_q.push_back('{at: cyc + j + 2, d: ref_mem[{m_row, CW'(col_of(m_base, j))}]});
            end
            3'd4: begin
              if (cyc >= act_e + T_RAS) begin m_open = 0; pre_e = cyc; end
              else m_err = 1;
            end
            default: m_err = 1;
          endcase
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd0, '0, '0, DW'($urandom));
  endtask

  // Holds the command valid until the model says it is taken (bounded).
  task automatic issue(input logic [2:0] c, input logic [RW-1:0] r, input logic [CW-1:0] col);
    bit acc;
    int n;
    n = 0;
    do begin
      acc = m_ready();
      step(1'b1, 1'b1, c, r, col, DW'($urandom));
      n++;
    end while (!acc && n < 64);
    check_eq("issue_accept", 32'(acc), 32'd1);
  endtask

  task automatic write_burst(input logic [RW-1:0] r, input logic [CW-1:0] col,
                             input logic [DW-1:0] d [BL]);
    issue(3'd3, r, col);
    for (int k = 0; k < BL; k++) step(1'b1, 1'b0, 3'd0, '0, '0, d[k]);
  endtask

  logic [DW-1:0] seq [BL];
  logic [2:0]    cmd_tab [12] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd6, 3'd7};
  int            bad;

  initial begin
    host.cmd_valid = 1'b0; host.cmd = '0; host.cmd_row = '0; host.cmd_col = '0; host.wdata = '0;
    repeat (2) @(posedge clk);
    cyc = 0;
    m_reset();
    step(1'b0, 1'b0, 3'd0, '0, '0, '0);
    step(1'b0, 1'b0, 3'd0, '0, '0, '0);
    idle(2);

    // Row 1: write 1..8 at col 0 and read back, then wrapped burst at col 5.
    issue(3'd1, 5'd1, '0);
    for (int k = 0; k < BL; k++) seq[k] = DW'(k + 1);
    write_burst(5'd1, 10'd0, seq);
    issue(3'd2, 5'd1, 10'd0);
    idle(BL + 2);
    check_eq("mem_r1_c3", 32'(bank_mem[{5'd1, 10'd3}]), 32'd4);
    seq = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h1, 4'h2};
    write_burst(5'd1, 10'd5, seq);
    issue(3'd2, 5'd1, 10'd5);
    idle(BL + 2);
    check_eq("mem_r1_c0_wrap", 32'(bank_mem[{5'd1, 10'd0}]), 32'hD);
    check_eq("mem_r1_c7", 32'(bank_mem[{5'd1, 10'd7}]), 32'hC);
    issue(3'd4, '0, '0);

    // RD right after ACT waits out tRCD.
    issue(3'd1, 5'd2, '0);
    issue(3'd2, 5'd2, 10'd0);
    idle(BL + 2);
    issue(3'd4, '0, '0);

    // Early PRE errors, legal PRE closes, ACT after tRP.
    issue(3'd1, 5'd3, '0);
    idle(T_RCD - 1);
    step(1'b1, 1'b1, 3'd4, '0, '0, '0);
    idle(T_RAS);
    issue(3'd4, '0, '0);
    issue(3'd1, 5'd4, '0);
    idle(T_RCD);
    step(1'b1, 1'b1, 3'd1, 5'd9, '0, '0);
    step(1'b1, 1'b1, 3'd7, '0, '0, '0);
    idle(T_RAS);
    issue(3'd4, '0, '0);
    idle(T_RP);
    step(1'b1, 1'b1, 3'd2, '0, '0, '0);
    idle(2);

    // Reset on beat 3 of a write burst.
    issue(3'd1, 5'd5, '0);
    issue(3'd3, 5'd5, 10'd0);
    step(1'b1, 1'b0, 3'd0, '0, '0, 4'h7);
    step(1'b1, 1'b0, 3'd0, '0, '0, 4'h8);
    step(1'b1, 1'b0, 3'd0, '0, '0, 4'h9);
    step(1'b0, 1'b0, 3'd0, '0, '0, 4'h6);
    step(1'b0, 1'b0, 3'd0, '0, '0, 4'h6);
    idle(2);
    check_eq("rst_mem_c2", 32'(bank_mem[{5'd5, 10'd2}]), 32'h9);
    check_eq("rst_mem_c3", 32'(bank_mem[{5'd5, 10'd3}]), 32'h0);

    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 399) != 0), ($urandom_range(0, 3) != 0),
           cmd_tab[$urandom_range(0, 11)], RW'($urandom_range(0, 3)), CW'($urandom),
           DW'($urandom));
    idle(BL + 3);

    bad = 0;
    for (int i = 0; i < MEMSZ; i++) if (bank_mem[i] !== ref_mem[i]) bad++;
    check_eq("mem_image", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bank_cmd_ctrl.md
Name: bank_cmd_ctrl

Overview:
Per-bank command sequencer sitting directly upstream of Bank. It accepts ACT/RD/WR/PRE commands over a valid/ready handshake and tracks the open row. It enforces tRCD, tRAS and tRP in clk cycles, expands each RD/WR into a BL-beat column burst on Bank's rd_o_wr/row/column/dqin, and returns Bank's dqout as a tagged read stream.

Parameters:
DEVICE_WIDTH, 4, data width per beat (matches Bank)
COLWIDTH, 10, column address width
CHWIDTH, 5, row address width
BL, 8, burst length in beats (power of 2, ≤ 2**COLWIDTH)
T_RCD, 3, cycles from ACT accept to first legal RD/WR accept (≥1)
T_RAS, 6, cycles from ACT accept to first legal PRE accept (≥T_RCD)
T_RP, 2, cycles from PRE accept until ACT is legal (≥1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at posedge
cmd  in  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, others illegal
cmd_row  in  CHWIDTH  row for ACT
cmd_col  in  COLWIDTH  start column for RD/WR
wdata  in  DEVICE_WIDTH  write beat; sampled on each write-burst cycle
wdata_req  out  1  high in the cycle wdata is consumed
rdata  out  DEVICE_WIDTH  read beat
rdata_valid  out  1  rdata qualifier
row_open  out  1  a row is active
open_row  out  CHWIDTH  currently active row
cmd_err  out  1  one-cycle pulse: illegal/out-of-state command dropped
bank_rd_o_wr  out  1  to Bank rd_o_wr (1 = write)
bank_row  out  CHWIDTH  to Bank row
bank_column  out  COLWIDTH  to Bank column
bank_dqin  out  DEVICE_WIDTH  to Bank dqin
bank_dqout  in  DEVICE_WIDTH  from Bank dqout (1-cycle registered read)

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; all outputs 0; timers and beat counter cleared. Reset mid-burst aborts immediately, with no further bank writes and no rdata_valid.
- States: IDLE, ACTIVATING, ACTIVE, WRITING, READING, PRECHARGING.
- cmd_ready=1 only in IDLE and ACTIVE; 0 otherwise. NOP is accepted and ignored.
- IDLE: ACT → latch cmd_row into open_row/bank_row, start tRCD and tRAS timers, go to ACTIVATING. RD/WR/PRE/illegal code → cmd_err=1 next cycle, command dropped, stay.
- ACTIVATING: after T_RCD cycles go to ACTIVE. row_open=1 from the cycle after ACT accept.
- ACTIVE:
  - WR → WRITING.
  - RD → READING.
  - PRE accepted only when tRAS has expired; otherwise cmd_ready stays 1, but cmd_err pulses and PRE is dropped.
  - PRE accepted → PRECHARGING, row_open=0 next cycle.
  - ACT in ACTIVE → cmd_err pulse, dropped.
- Burst column sequence: beat k (0..BL-1) column = {cmd_col[COLWIDTH-1:log2 BL], (cmd_col[log2 BL-1:0]+k) mod BL}. The sequence wraps inside the BL-aligned block and never carries into upper bits.
- WRITING: for BL consecutive cycles, bank_rd_o_wr=1, bank_column = beat column, bank_dqin = wdata, wdata_req=1. Then return to ACTIVE with bank_rd_o_wr=0.
- READING: for BL consecutive cycles, bank_rd_o_wr=0 and bank_column = beat column. Bank returns data one cycle later, so rdata = bank_dqout and rdata_valid=1 in cycles 1..BL after the first column drive. The trailing valid beat overlaps the first ACTIVE cycle.
- Back-to-back: a RD/WR may be accepted in the first ACTIVE cycle after a burst.
- PRECHARGING: T_RP cycles, then IDLE. bank_row is held at the last open row; Bank is never written outside WRITING.
- Timers saturate at 0. tRAS keeps counting through bursts.
- Outside bursts, bank_column=0 and bank_dqin=0.

Decomposition:
- Package bank_ctrl_pkg holds:
  - cmd_e enum (NOP/ACT/RD/WR/PRE)
  - state_e enum
  - a function computing the wrapped burst column
- One natural sub-module, bank_burst_gen: beat counter plus wrapped column generator, with start/done handshake, shared by read and write paths. Timers stay inline.

Test Plan:
- Reset then ACT row 1, WR col 0 with wdata 1..8, RD col 0 → Bank row 1 cols 0..7 written. rdata_valid for exactly 8 cycles with rdata 1..8.
- WR at col 5, BL=8, data A..H → columns 5,6,7,0,1,2,3,4 get A..H. RD col 5 returns A..H in that order.
- RD issued 1 cycle after ACT → cmd_ready=0 during ACTIVATING. RD is accepted exactly T_RCD cycles after ACT, and the first column drive follows in the next cycle.
- PRE issued 2 cycles after ACT reaches ACTIVE before T_RAS → cmd_err pulses once and row stays open. PRE at ≥T_RAS → row_open=0, IDLE after T_RP; ACT is then accepted.
- RD in IDLE, ACT in ACTIVE, cmd=7 → each gives one cmd_err pulse, with no Bank write and no state change.
- rst_n=0 on beat 3 of a write burst → beats 3..7 not written, and all outputs are 0 the next cycle.
